// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : stage payload structs, bubble values and occupancy encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0000_0001;
  localparam logic [31:0] PC_BUBBLE = 32'hffff_fffc;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_HEAD  = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fd_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } de_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
  } ew_t;

  localparam fd_t FD_BUBBLE = '{inst: NOP_INST, pc: PC_BUBBLE};
  localparam de_t DE_BUBBLE = '{inst: NOP_INST, pc: PC_BUBBLE, rs1_val: 32'h0, rs2_val: 32'h0};
  localparam ew_t EW_BUBBLE = '{result: 32'h0, rd: 5'd0, we: 1'b0};

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_slot : one payload+valid register; clear (to BUBBLE) beats load
// Revision  : 1.0
// ---------------------------------------------------------------------------
module pipe_slot #(
  parameter int                 WIDTH  = 32,
  parameter logic [WIDTH-1:0]   BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= BUBBLE;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_q     <= BUBBLE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg : valid/ready pipeline stage with optional 2-entry skid buffer
// Revision      : 1.0
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             w_accept;
  logic             w_emit;
  logic             w_head_valid;
  logic [WIDTH-1:0] w_head_data;
  logic             w_skid_valid;
  logic [WIDTH-1:0] w_skid_data;
  logic             w_head_load;
  logic             w_head_clr;
  logic [WIDTH-1:0] w_head_d;
  logic             w_skid_load;
  logic             w_skid_clr;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = w_head_valid & out_ready;

  always_comb begin
    w_head_load = 1'b0;
    w_head_clr  = 1'b0;
    w_head_d    = in_data;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    if (flush) begin
      w_head_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else if (w_skid_valid) begin
      // Skid entry is older than anything upstream, so it refills the head first.
      if (w_emit) begin
        w_head_load = 1'b1;
        w_head_d    = w_skid_data;
        w_skid_clr  = 1'b1;
      end
    end else if (w_head_valid) begin
      if (w_emit && w_accept) begin
        w_head_load = 1'b1;
      end else if (w_emit) begin
        w_head_clr = 1'b1;
      end else if (w_accept) begin
        w_skid_load = 1'b1;
      end
    end else if (w_accept) begin
      w_head_load = 1'b1;
    end
  end

  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_head (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_head_clr),
    .i_load  (w_head_load),
    .i_d     (w_head_d),
    .o_valid (w_head_valid),
    .o_q     (w_head_data)
  );

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;

      pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_skid_clr),
        .i_load  (w_skid_load),
        .i_d     (in_data),
        .o_valid (w_skid_valid),
        .o_q     (w_skid_data)
      );

      // Ready is the registered complement of next-cycle skid occupancy.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else if (flush) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= ~(w_skid_load | (w_skid_valid & ~w_skid_clr));
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_flat
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = BUBBLE;
      assign in_ready     = out_ready | ~w_head_valid;
    end
  endgenerate

  assign out_valid = w_head_valid;
  assign out_data  = w_head_data;
  assign count     = w_skid_valid ? CNT_FULL : (w_head_valid ? CNT_HEAD : CNT_EMPTY);

endmodule : pipe_skid_reg
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg : queue-model scoreboard for SKID=1 (index 0) and SKID=0 (index 1)
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam logic [31:0] BUB = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic        ordy [2];
  logic        fl   [2];
  logic [31:0] id   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [31:0] od   [2];
  logic [1:0]  cnt  [2];

  logic [31:0] mq [2][$];
  logic        acc_last   [2];
  logic        stall_prev [2];
  logic [31:0] d_prev     [2];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .BUBBLE(BUB), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .count(cnt[0])
  );

  pipe_skid_reg #(.WIDTH(32), .BUBBLE(BUB), .SKID(1'b0)) u_flat (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .count(cnt[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Reference: a plain FIFO of capacity 2 (SKID=1) or 1 (SKID=0), checked mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        int   sz;
        logic eir, emit, acc;
        sz   = mq[k].size();
        eir  = (k == 0) ? (sz < 2) : (ordy[k] || sz == 0);
        chk("count",     k, {30'b0, cnt[k]}, sz);
        chk("in_ready",  k, {31'b0, ir[k]},  {31'b0, eir});
        chk("out_valid", k, {31'b0, ov[k]},  {31'b0, sz != 0});
        chk("out_data",  k, od[k], (sz != 0) ? mq[k][0] : BUB);
        assert (!stall_prev[k] || (iv[k] && id[k] == d_prev[k]))
          else $error("upstream dropped stalled data on port %0d", k);
        emit = (sz != 0) && ordy[k];
        acc  = iv[k] && eir;
        if (fl[k]) begin
          mq[k].delete();
        end else begin
          if (emit) void'(mq[k].pop_front());
          if (acc)  mq[k].push_back(id[k]);
        end
        stall_prev[k] = iv[k] && !eir && !fl[k];
        d_prev[k]     = id[k];
        acc_last[k]   = acc || fl[k];
      end
    end else begin
      for (int k = 0; k < 2; k++) stall_prev[k] = 1'b0;
    end
  end

  task automatic push(input int k, input logic [31:0] d);
    logic a;
    int   t;
    t     = 0;
    iv[k] = 1'b1;
    id[k] = d;
    do begin
      @(negedge clk);
      a = ir[k];
      @(posedge clk);
      #1;
      t++;
    end while (!a && t < 40);
    n_chk++;
    if (!a) begin
      n_fail++;
      $display("FAIL push_timeout[%0d] data %h never accepted, expected accept within 40 cycles", k, d);
    end
    iv[k] = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_out_valid"}, k, {31'b0, ov[k]}, 32'd0);
      chk({tag, "_out_data"},  k, od[k], BUB);
      chk({tag, "_count"},     k, {30'b0, cnt[k]}, 32'd0);
      chk({tag, "_in_ready"},  k, {31'b0, ir[k]}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0; id[k] = 32'h0;
      acc_last[k] = 1'b0; stall_prev[k] = 1'b0; d_prev[k] = 32'h0;
    end
    #2;
    reset_checks("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back streaming with simultaneous emit/accept on both variants
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; id[0] = 32'hA0 + i;
      iv[1] = 1'b1; id[1] = 32'hE0 + i;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0; iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure fills the skid; B2 waits until downstream frees a slot
    ordy[0] = 1'b0;
    push(0, 32'hB0);
    push(0, 32'hB1);
    iv[0] = 1'b1; id[0] = 32'hB2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_count",    0, {30'b0, cnt[0]}, 32'd2);
    chk("bp_in_ready", 0, {31'b0, ir[0]},  32'd0);
    chk("bp_head",     0, od[0], 32'hB0);
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    push(0, 32'hB2);
    repeat (4) @(posedge clk);
    #1;

    // Flush a full stage while a new word is offered; that word must vanish
    ordy[0] = 1'b0;
    push(0, 32'hC0);
    push(0, 32'hC1);
    iv[0] = 1'b1; id[0] = 32'hC9; fl[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    chk("flush_count", 0, {30'b0, cnt[0]}, 32'd0);
    chk("flush_data",  0, od[0], BUB);
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    push(0, 32'hCA);
    @(negedge clk);
    chk("post_flush_data",  0, od[0], 32'hCA);
    chk("post_flush_valid", 0, {31'b0, ov[0]}, 32'd1);
    @(posedge clk); #1;

    // Single-entry variant: ready follows out_ready combinationally while holding
    ordy[1] = 1'b0;
    push(1, 32'hD0);
    @(negedge clk);
    chk("flat_ready_low", 1, {31'b0, ir[1]}, 32'd0);
    ordy[1] = 1'b1;
    #1;
    chk("flat_ready_high", 1, {31'b0, ir[1]}, 32'd1);
    @(posedge clk); #1;

    // Random valid/ready/flush traffic on both variants
    for (int k = 0; k < 2; k++) acc_last[k] = 1'b1;
    repeat (300) begin
      for (int k = 0; k < 2; k++) begin
        ordy[k] = ($urandom_range(0, 3) != 0);
        fl[k]   = ($urandom_range(0, 19) == 0);
        if (!iv[k] || acc_last[k]) begin
          iv[k] = ($urandom_range(0, 2) != 0);
          id[k] = $urandom;
        end
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of traffic, checked before any edge
    #2;
    rst = 1'b1;
    #1;
    reset_checks("rst_mid");
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push(0, 32'hF0);
    push(1, 32'hF1);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pipe_skid_reg
`default_nettype wire
